// File: rtl/param_register_file.sv
// Parametrised register file with hardwired-zero r0, post-reset constant loader and pixel capture port.
// Optional same-cycle write forwarding is enabled by defining PARAM_REGFILE_BYPASS_EN.
module param_register_file #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int PIX_W   = 12,
    parameter int IDX_REG = 11,
    parameter int IMG_REG = 12,
    parameter int WM_REG  = 13,
    parameter int OUT_REG = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  image_in,
    input  logic [PIX_W-1:0]  water_in,
    output logic [PIX_W-1:0]  pix_out,
    output logic [PIX_W-1:0]  pix_index,
    output logic              init_busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = '1;
    localparam logic [ADDR_W-1:0] IDX_A = ADDR_W'(IDX_REG);
    localparam logic [ADDR_W-1:0] IMG_A = ADDR_W'(IMG_REG);
    localparam logic [ADDR_W-1:0] WM_A  = ADDR_W'(WM_REG);
    localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_REG);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] regmem [DEPTH];
    logic [DATA_W-1:0] img_ext;
    logic [DATA_W-1:0] wm_ext;

    assign img_ext = DATA_W'(image_in);
    assign wm_ext  = DATA_W'(water_in);

    // Constants the firmware relies on: one, full-scale pixel, green and blue channel masks.
    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W-1:0] idx);
        logic [DATA_W-1:0] chan;
        chan = (DATA_W'(1) << (PIX_W / 3)) - DATA_W'(1);
        case (idx)
            ADDR_W'(9):  return DATA_W'(1);
            ADDR_W'(10): return (DATA_W'(1) << PIX_W) - DATA_W'(1);
            ADDR_W'(19): return chan << (PIX_W / 3);
            ADDR_W'(20): return chan;
            default:     return '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regmem[a];
`ifdef PARAM_REGFILE_BYPASS_EN
        if (we && (waddr != '0) && (a == waddr)) v = wdata;
        // Pixel capture overrides a colliding CPU write, so it is forwarded last.
        if (pix_valid && (a == IMG_A)) v = img_ext;
        if (pix_valid && (a == WM_A))  v = wm_ext;
`endif
        if ((state != RUN) || (a == '0)) v = '0;
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    // Array is deliberately not cleared by reset; the init sequencer rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                regmem[cnt] <= init_value(cnt);
            end else begin
                if (we && (waddr != '0)) regmem[waddr] <= wdata;
                if (pix_valid) begin
                    regmem[IMG_A] <= img_ext;
                    regmem[WM_A]  <= wm_ext;
                end
            end
        end
    end

    always_comb begin
        rdata1    = read_value(raddr1);
        rdata2    = read_value(raddr2);
        pix_out   = PIX_W'(read_value(OUT_A));
        pix_index = PIX_W'(read_value(IDX_A));
    end
endmodule

// File: tb/tb_param_register_file.sv
// Randomised and directed bench for param_register_file against an array-based reference model.
// Honours PARAM_REGFILE_BYPASS_EN when computing expected same-cycle reads.
module tb_param_register_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        pix_valid;
    logic [11:0] image_in;
    logic [11:0] water_in;
    logic [11:0] pix_out;
    logic [11:0] pix_index;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic        m_busy;
    int          m_cnt;

    param_register_file dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .pix_valid(pix_valid), .image_in(image_in), .water_in(water_in),
        .pix_out(pix_out), .pix_index(pix_index), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] const_value(input int i);
        case (i)
            9:       return 32'h1;
            10:      return 32'hFFF;
            19:      return 32'hF0;
            20:      return 32'h0F;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (m_busy || a == 0) return 32'h0;
`ifdef PARAM_REGFILE_BYPASS_EN
        if (pix_valid && a == 12) return {20'h0, image_in};
        if (pix_valid && a == 13) return {20'h0, water_in};
        if (we && waddr != 5'd0 && a == int'(waddr)) return wdata;
`endif
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply the spec's edge rules to the model, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (m_busy) begin
            model[m_cnt] = const_value(m_cnt);
            m_cnt++;
            if (m_cnt == 32) m_busy = 1'b0;
        end else begin
            if (we && waddr != 5'd0) model[waddr] = wdata;
            if (pix_valid) begin
                model[12] = {20'h0, image_in};
                model[13] = {20'h0, water_in};
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; pix_valid = 1'b0;
        image_in = '0; water_in = '0;
    endtask

    task automatic write(input int a, input logic [31:0] d);
        we = 1'b1; waddr = 5'(a); wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic busy_count(input string tag, input bit probe_reads);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            if (probe_reads && n == 5) begin
                raddr1 = 5'd9; raddr2 = 5'd10; #1;
                check("init_rdata1_zero", rdata1, 32'h0);
                check("init_pix_out_zero", {20'h0, pix_out}, 32'h0);
            end
            n++;
            tick();
        end
        check(tag, 32'(n), 32'd32);
    endtask

    initial begin
        logic [31:0] e;
        int a;
        m_busy = 1'b1; m_cnt = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        idle();
        raddr1 = '0; raddr2 = '0;
        rst_n = 1'b0;
        @(negedge clk);
        tick(); tick();
        check("reset_busy", {31'h0, init_busy}, 32'h1);

        // 1: init sequence length and constant table
        rst_n = 1'b1;
        busy_count("init_busy_len", 1'b1);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(31 - i); #1;
            check("init_r1", rdata1, const_value(i));
            check("init_r2", rdata2, const_value(31 - i));
            tick();
        end

        // 2: plain write and hardwired zero
        write(7, 32'hDEADBEEF);
        raddr1 = 5'd7; #1; check("r7_write", rdata1, 32'hDEADBEEF);
        write(0, 32'h1234);
        raddr1 = 5'd0; #1; check("r0_zero", rdata1, 32'h0);

        // 3: pixel capture beats a colliding CPU write
        write(12, 32'hFFFFFFFF);
        pix_valid = 1'b1; image_in = 12'hABC; water_in = 12'h123;
        we = 1'b1; waddr = 5'd13; wdata = 32'hCAFEF00D;
        tick();
        idle();
        raddr1 = 5'd12; raddr2 = 5'd13; #1;
        check("img_capture", rdata1, 32'h00000ABC);
        check("wm_capture", rdata2, 32'h00000123);

        // 4: exported pixel registers
        write(14, 32'h0005A5A5);
        write(11, 32'h00001007);
        #1;
        check("pix_out", {20'h0, pix_out}, 32'h5A5);
        check("pix_index", {20'h0, pix_index}, 32'h007);

        // 6: same-cycle read of a register being written
        write(6, 32'h11);
        we = 1'b1; waddr = 5'd6; wdata = 32'h55; raddr1 = 5'd6; #1;
`ifdef PARAM_REGFILE_BYPASS_EN
        check("rdw_bypass", rdata1, 32'h55);
`else
        check("rdw_old", rdata1, 32'h11);
`endif
        tick();
        we = 1'b0; #1;
        check("rdw_after", rdata1, 32'h55);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            we        = ($urandom_range(0, 3) != 0);
            a         = $urandom_range(0, 7);
            waddr     = (a < 4) ? 5'(a + 11) : ((a == 4) ? 5'd0 : 5'($urandom_range(0, 31)));
            wdata     = $urandom;
            pix_valid = ($urandom_range(0, 3) == 0);
            image_in  = 12'($urandom);
            water_in  = 12'($urandom);
            raddr1    = ($urandom_range(0, 1) != 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2    = 5'($urandom_range(11, 14));
            #1;
            check("rnd_r1", rdata1, exp_read(int'(raddr1)));
            check("rnd_r2", rdata2, exp_read(int'(raddr2)));
            e = exp_read(14); check("rnd_pix_out", {20'h0, pix_out}, {20'h0, e[11:0]});
            e = exp_read(11); check("rnd_pix_index", {20'h0, pix_index}, {20'h0, e[11:0]});
            tick();
        end
        idle();

        // 5: reset mid-init restarts the sequence; CPU writes during init are dropped
        write(3, 32'hA5A5A5A5);
        raddr1 = 5'd3; #1; check("r3_before", rdata1, 32'hA5A5A5A5);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'h77777777;
        tick();
        rst_n = 1'b1;
        busy_count("restart_busy_len", 1'b0);
        we = 1'b0; raddr1 = 5'd3; raddr2 = 5'd9; #1;
        check("r3_after_init", rdata1, 32'h0);
        check("r9_after_init", rdata2, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised, reset-initialised general-purpose register file for the watermark soft processor; next generation of the fixed 32x32 register file.
- Adds a synchronous active-low reset.
- Adds a hardware init sequencer that loads the constant registers (one, max value, colour masks) after every reset.
- Adds a valid-qualified pixel capture port and a hardwired-zero register 0.
- Sits between the decode/ALU datapath and the VGA/image-ROM pixel path.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
PIX_W, 12, pixel width (4-bit R,G,B)
IDX_REG, 11, register exported as pixel counter
IMG_REG, 12, register loaded from image_in
WM_REG, 13, register loaded from water_in
OUT_REG, 14, register exported as output pixel

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
we  in  1  write enable (1 = write)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr1  in  ADDR_W  read address A
raddr2  in  ADDR_W  read address B
rdata1  out  DATA_W  read data A
rdata2  out  DATA_W  read data B
pix_valid  in  1  capture image_in/water_in this cycle
image_in  in  PIX_W  image pixel
water_in  in  PIX_W  watermark pixel
pix_out  out  PIX_W  regmem[OUT_REG][PIX_W-1:0]
pix_index  out  PIX_W  regmem[IDX_REG][PIX_W-1:0]
init_busy  out  1  high while init sequencer runs

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset: sampled only on a clk rising edge with rst_n=0.
  - FSM goes to INIT; init counter = 0; init_busy = 1 from the next cycle.
  - Array contents are not cleared by reset itself.
- FSM states:
  - INIT: each cycle writes init_value(cnt) to regmem[cnt], then cnt++. After writing cnt = DEPTH-1, goes to RUN and clears init_busy. Duration is exactly DEPTH cycles after reset release; 32 with defaults.
  - RUN: normal operation. It is left only via reset.
- Reset asserted mid-INIT: counter returns to 0 and the sequence restarts from the beginning.
- init_value table; all other entries 0:
  - reg 9 = 1
  - reg 10 = 2**PIX_W-1
  - reg 19 = green mask, bits [2*PIX_W/3-1 : PIX_W/3] set (0x0F0 at PIX_W = 12)
  - reg 20 = blue mask, bits [PIX_W/3-1 : 0] set (0x00F at PIX_W = 12)
- During INIT:
  - we and pix_valid are ignored.
  - rdata1, rdata2, pix_out and pix_index read 0.
- Reads in RUN: combinational from the array. rdata = regmem[raddr] as updated by the last clock edge.
- Address 0: always reads 0; writes to it are discarded.
- Write in RUN: when we=1 and waddr≠0, regmem[waddr] <= wdata at the rising edge.
- Pixel capture in RUN: when pix_valid=1:
  - regmem[IMG_REG] <= zero-extended image_in
  - regmem[WM_REG] <= zero-extended water_in
  - Upper bits are cleared, not preserved.
- Collision: if we targets IMG_REG or WM_REG in the same cycle as pix_valid, the pixel capture wins for that register. Other registers still take the CPU write.
- Without pix_valid, IMG_REG and WM_REG hold their value and are CPU-writable.
- Read-during-write, same cycle: returns the old value, unless BYPASS_EN is defined.
- Exported outputs: pix_out and pix_index are truncations to PIX_W; no extra latency.

Optional Feature:
Macro: PARAM_REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding in RUN. If we=1, waddr≠0 and raddrN==waddr, rdataN = wdata combinationally in the same cycle.
  - A pixel capture to IMG_REG or WM_REG forwards the zero-extended pixel in the same way and takes priority over wdata.
  - Forwarding also applies to pix_out and pix_index.
- Undefined: no forwarding; a read returns the pre-edge array value.

Test Plan:
1. Hold rst_n=0 for 2 cycles, then release. Required: init_busy=1 for exactly 32 cycles. Afterwards raddr1=9 reads 1, raddr2=10 reads 0xFFF, reg19 reads 0xF0, reg20 reads 0x0F, reg 5 reads 0.
2. In RUN, write 0xDEADBEEF to reg 7 and read it the next cycle. Required: 0xDEADBEEF. Write 0x1234 to reg 0. Required: reg 0 reads 0.
3. Write 0xFFFFFFFF to reg 12, then pix_valid=1 with image_in=0xABC and water_in=0x123 in the same cycle as another we to reg 13. Required: reg12 = 0x00000ABC, reg13 = 0x00000123.
4. Write reg14 = 0x5A5A5, reg11 = 0x1007. Required: pix_out = 0x5A5, pix_index = 0x007.
5. Pulse rst_n=0 at init cycle 10, and attempt we=1 to reg 3 during INIT. Required: init_busy stays high 32 cycles after release, and reg 3 reads 0 afterwards.
6. Same cycle we=1, waddr=raddr1=6, wdata=0x55. Required: rdata1 = 0x55 with PARAM_REGFILE_BYPASS_EN defined, and the old value without it.
